// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Forward-select codes match the exec operand mux ordering.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MDU_WAIT = 2'b01,
        MDU_DONE = 2'b10
    } t_hazard_state;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/forward_sel.sv
// Exec operand bypass select: compares one source register against mem and wb destinations.
// The mem stage holds the younger result, so it wins over wb.
module forward_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic                  we_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  we_wb,
    output logic [1:0]            fwd
);

    always_comb begin
        fwd = FWD_NONE;
        // x0 is hardwired to zero and must never be bypassed
        if (rs != '0) begin
            if (we_mem && (rs == rd_mem)) begin
                fwd = FWD_MEM;
            end else if (we_wb && (rs == rd_wb)) begin
                fwd = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use, branch flush, MDU sequencing, cache freeze.
// Define HAZARD_PERF_CNT_EN to add the stall-cycle and flush-event performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MDU_LATENCY = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
    input  logic                  i_load_instr_exec,
    input  logic                  i_mdu_instr_exec,
    input  logic                  i_branch_taken_exec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
    input  logic                  i_reg_we_mem,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
    input  logic                  i_reg_we_wb,
    input  logic                  i_icache_stall,
    input  logic                  i_dcache_stall,
    output logic                  o_stall_fetch,
    output logic                  o_stall_decode,
    output logic                  o_stall_exec,
    output logic                  o_stall_mem,
    output logic                  o_flush_decode,
    output logic                  o_flush_exec,
    output logic                  o_flush_mem,
    output logic [1:0]            o_forward_rs1,
    output logic [1:0]            o_forward_rs2,
    output logic                  o_mdu_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           o_stall_cycles,
    output logic [31:0]           o_flush_events
`endif
);

    localparam int unsigned CNT_W = $clog2(MDU_LATENCY);

    t_hazard_state    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_stall;
    logic             load_use;
    logic [1:0]       fwd_rs1, fwd_rs2;

    assign mem_stall = i_icache_stall | i_dcache_stall;
    assign load_use  = i_load_instr_exec && (i_rd_addr_exec != '0) &&
                       ((i_rd_addr_exec == i_rs1_addr_dec) || (i_rd_addr_exec == i_rs2_addr_dec));

    forward_sel #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs1 (
        .rs     (i_rs1_addr_exec),
        .rd_mem (i_rd_addr_mem),
        .we_mem (i_reg_we_mem),
        .rd_wb  (i_rd_addr_wb),
        .we_wb  (i_reg_we_wb),
        .fwd    (fwd_rs1)
    );

    forward_sel #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_rs2 (
        .rs     (i_rs2_addr_exec),
        .rd_mem (i_rd_addr_mem),
        .we_mem (i_reg_we_mem),
        .rd_wb  (i_rd_addr_wb),
        .we_wb  (i_reg_we_wb),
        .fwd    (fwd_rs2)
    );

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // A cache stall freezes the sequencer along with the rest of the pipe
        if (!mem_stall) begin
            case (state_q)
                RUN: begin
                    if (!i_branch_taken_exec && i_mdu_instr_exec) begin
                        state_d = MDU_WAIT;
                        cnt_d   = CNT_W'(MDU_LATENCY - 2);
                    end
                end
                MDU_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = MDU_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                MDU_DONE: state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    always_comb begin
        o_stall_fetch  = 1'b0;
        o_stall_decode = 1'b0;
        o_stall_exec   = 1'b0;
        o_stall_mem    = 1'b0;
        o_flush_decode = 1'b0;
        o_flush_exec   = 1'b0;
        o_flush_mem    = 1'b0;
        o_forward_rs1  = FWD_NONE;
        o_forward_rs2  = FWD_NONE;
        o_mdu_busy     = 1'b0;
        if (!i_arst) begin
            o_forward_rs1 = fwd_rs1;
            o_forward_rs2 = fwd_rs2;
            o_mdu_busy    = (state_q == MDU_WAIT);
            if (mem_stall) begin
                o_stall_fetch  = 1'b1;
                o_stall_decode = 1'b1;
                o_stall_exec   = 1'b1;
                o_stall_mem    = 1'b1;
            end else begin
                case (state_q)
                    RUN, MDU_DONE: begin
                        if (i_branch_taken_exec) begin
                            o_flush_decode = 1'b1;
                            o_flush_exec   = 1'b1;
                        end else if (i_mdu_instr_exec && (state_q == RUN)) begin
                            o_stall_fetch  = 1'b1;
                            o_stall_decode = 1'b1;
                            o_stall_exec   = 1'b1;
                            o_flush_mem    = 1'b1;
                        end else if (load_use) begin
                            o_stall_fetch  = 1'b1;
                            o_stall_decode = 1'b1;
                            o_flush_exec   = 1'b1;
                        end
                    end
                    MDU_WAIT: begin
                        o_stall_fetch  = 1'b1;
                        o_stall_decode = 1'b1;
                        o_stall_exec   = 1'b1;
                        o_flush_mem    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (o_stall_fetch) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (o_flush_decode || o_flush_exec) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
        end
    end

    assign o_stall_cycles = stall_cycles_q;
    assign o_flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed plan sequences followed by random traffic.
// Define HAZARD_PERF_CNT_EN to also check the performance counters.
module tb_hazard_ctrl;

    localparam int unsigned AW  = 5;
    localparam int unsigned LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1_dec, rs2_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb;
    logic          load_exec, mdu_exec, branch_exec, we_mem, we_wb, icache, dcache;
    logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, busy;
    logic [1:0]    fwd1, fwd2;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cycles, flush_events;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_ADDR_W  (AW),
        .MDU_LATENCY (LAT)
    ) dut (
        .i_clk               (clk),
        .i_arst              (rst),
        .i_rs1_addr_dec      (rs1_dec),
        .i_rs2_addr_dec      (rs2_dec),
        .i_rs1_addr_exec     (rs1_exec),
        .i_rs2_addr_exec     (rs2_exec),
        .i_rd_addr_exec      (rd_exec),
        .i_load_instr_exec   (load_exec),
        .i_mdu_instr_exec    (mdu_exec),
        .i_branch_taken_exec (branch_exec),
        .i_rd_addr_mem       (rd_mem),
        .i_reg_we_mem        (we_mem),
        .i_rd_addr_wb        (rd_wb),
        .i_reg_we_wb         (we_wb),
        .i_icache_stall      (icache),
        .i_dcache_stall      (dcache),
        .o_stall_fetch       (stall_f),
        .o_stall_decode      (stall_d),
        .o_stall_exec        (stall_e),
        .o_stall_mem         (stall_m),
        .o_flush_decode      (flush_d),
        .o_flush_exec        (flush_e),
        .o_flush_mem         (flush_m),
        .o_forward_rs1       (fwd1),
        .o_forward_rs2       (fwd2),
        .o_mdu_busy          (busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_stall_cycles      (stall_cycles),
        .o_flush_events      (flush_events)
`endif
    );

    typedef struct {
        logic [11:0] ctl;      // {sf,sd,se,sm,fd,fe,fm,fwd1,fwd2,busy}
        bit          chk_cnt;
        logic [31:0] sc;
        logic [31:0] fe;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: MDU tracked as "remaining wait cycles" plus a one-shot done marker
    int          wait_left = 0;
    bit          after_mdu = 1'b0;
    int unsigned m_sc = 0;
    int unsigned m_fe = 0;
    bit          cnt_known = 1'b0;

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
        if (rs == 0) return 2'b00;
        if (we_mem && rs == rd_mem) return 2'b10;
        if (we_wb && rs == rd_wb) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step(input string tag);
        exp_t e;
        logic sf, sd, se, sm, fd, fx, fm, b;
        logic [1:0] f1, f2;
        bit lu;
        {sf, sd, se, sm, fd, fx, fm, b} = '0;
        f1 = 2'b00;
        f2 = 2'b00;
        lu = load_exec && rd_exec != 0 && (rd_exec == rs1_dec || rd_exec == rs2_dec);
        if (rst) begin
            wait_left = 0;
            after_mdu = 1'b0;
        end else begin
            f1 = ref_fwd(rs1_exec);
            f2 = ref_fwd(rs2_exec);
            b  = (wait_left > 0);
            if (icache || dcache) begin
                {sf, sd, se, sm} = 4'b1111;
            end else if (wait_left > 0) begin
                {sf, sd, se, fm} = 4'b1111;
                wait_left--;
                if (wait_left == 0) after_mdu = 1'b1;
            end else begin
                if (branch_exec) begin
                    {fd, fx} = 2'b11;
                end else if (mdu_exec && !after_mdu) begin
                    {sf, sd, se, fm} = 4'b1111;
                    wait_left = LAT - 2;
                end else if (lu) begin
                    {sf, sd, fx} = 3'b111;
                end
                after_mdu = 1'b0;
            end
        end
        e.ctl     = {sf, sd, se, sm, fd, fx, fm, f1, f2, b};
        e.chk_cnt = cnt_known;
        e.sc      = m_sc;
        e.fe      = m_fe;
        e.tag     = tag;
        exp_q.push_back(e);
        if (rst) begin
            m_sc = 0;
            m_fe = 0;
            cnt_known = 1'b1;
        end else begin
            if (sf) m_sc++;
            if (fd || fx) m_fe++;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [11:0] act;
        cyc++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, fwd1, fwd2, busy};
            n_tests++;
            if (act !== e.ctl) begin
                n_fail++;
                $display("FAIL %s cyc=%0d ctl{sf,sd,se,sm,fd,fe,fm,f1,f2,busy} got=%b want=%b",
                         e.tag, cyc, act, e.ctl);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (e.chk_cnt) begin
                n_tests++;
                if (stall_cycles !== e.sc || flush_events !== e.fe) begin
                    n_fail++;
                    $display("FAIL %s_perf cyc=%0d got sc=%0d fe=%0d want sc=%0d fe=%0d",
                             e.tag, cyc, stall_cycles, flush_events, e.sc, e.fe);
                end
            end
`endif
        end
    end

    task automatic clear_inputs();
        {rs1_dec, rs2_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb} = '0;
        {load_exec, mdu_exec, branch_exec, we_mem, we_wb, icache, dcache} = '0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        step("reset");
        step("reset");
        rst = 1'b0;
        step("idle");

        // Forwarding priority and x0 suppression
        rs1_exec = 5; rd_mem = 5; we_mem = 1; rd_wb = 5; we_wb = 1;
        step("fwd_mem");
        rd_mem = 0; rs2_exec = 5;
        step("fwd_wb");
        rs1_exec = 0;
        step("fwd_x0");
        clear_inputs();

        // Load-use and its x0 exception
        load_exec = 1; rd_exec = 7; rs2_dec = 7;
        step("load_use");
        load_exec = 0;
        step("load_use_after");
        load_exec = 1; rd_exec = 0; rs2_dec = 0;
        step("load_use_rd0");
        rd_exec = 7; rs2_dec = 7; branch_exec = 1;
        step("branch_over_lu");
        clear_inputs();
        step("idle");

        // Plain MDU sequence
        mdu_exec = 1;
        repeat (LAT) step("mdu");
        mdu_exec = 0;
        step("mdu_post");

        // MDU stretched by a data-cache stall
        mdu_exec = 1;
        step("mdu_ds");
        dcache = 1;
        step("mdu_ds_hold");
        step("mdu_ds_hold");
        dcache = 0;
        repeat (3) step("mdu_ds");
        mdu_exec = 0;
        step("mdu_ds_post");

        // Reset in the middle of MDU wait
        mdu_exec = 1;
        step("mdu_rst");
        step("mdu_rst");
        rst = 1'b1;
        step("mdu_rst_assert");
        rst = 1'b0;
        mdu_exec = 0;
        step("mdu_rst_after");

        // Random traffic over a small register set so that matches are frequent
        for (int i = 0; i < 2000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            rs1_dec     = AW'($urandom_range(0, 7));
            rs2_dec     = AW'($urandom_range(0, 7));
            rs1_exec    = AW'($urandom_range(0, 7));
            rs2_exec    = AW'($urandom_range(0, 7));
            rd_exec     = AW'($urandom_range(0, 7));
            rd_mem      = AW'($urandom_range(0, 7));
            rd_wb       = AW'($urandom_range(0, 7));
            we_mem      = $urandom_range(0, 1) == 1;
            we_wb       = $urandom_range(0, 1) == 1;
            load_exec   = $urandom_range(0, 2) == 0;
            mdu_exec    = $urandom_range(0, 5) == 0;
            branch_exec = $urandom_range(0, 7) == 0;
            icache      = $urandom_range(0, 9) == 0;
            dcache      = $urandom_range(0, 9) == 0;
            step("random");
        end

        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core.
- Drives stall and flush controls for the fetch, decode, exec and mem pipeline registers. Its o_flush_exec feeds the flush input of the decode→exec register.
- Resolves RAW forwarding for the exec-stage operands.
- Detects load-use hazards and branch redirects.
- Sequences a fixed-latency multi-cycle MUL/DIV held in exec through an FSM and counter.
- Freezes the whole pipe on cache stalls.

Parameters:
- REG_ADDR_W, 5, register address width.
- MDU_LATENCY, 4, total cycles an MDU instruction occupies exec (min 3).

Ports:
- i_clk  in  1  clock
- i_arst  in  1  synchronous active-high reset
- i_rs1_addr_dec  in  REG_ADDR_W  decode-stage rs1
- i_rs2_addr_dec  in  REG_ADDR_W  decode-stage rs2
- i_rs1_addr_exec  in  REG_ADDR_W  exec-stage rs1
- i_rs2_addr_exec  in  REG_ADDR_W  exec-stage rs2
- i_rd_addr_exec  in  REG_ADDR_W  exec-stage rd
- i_load_instr_exec  in  1  exec holds a load
- i_mdu_instr_exec  in  1  exec holds a MUL/DIV
- i_branch_taken_exec  in  1  taken branch/jump resolved in exec
- i_rd_addr_mem  in  REG_ADDR_W  mem-stage rd
- i_reg_we_mem  in  1  mem-stage register write enable
- i_rd_addr_wb  in  REG_ADDR_W  wb-stage rd
- i_reg_we_wb  in  1  wb-stage register write enable
- i_icache_stall  in  1  instruction cache busy
- i_dcache_stall  in  1  data cache busy
- o_stall_fetch, o_stall_decode, o_stall_exec, o_stall_mem  out  1 each  hold the stage register
- o_flush_decode, o_flush_exec, o_flush_mem  out  1 each  bubble into the stage register
- o_forward_rs1, o_forward_rs2  out  2 each  exec operand select
- o_mdu_busy  out  1  high in MDU_WAIT

Behaviour:
- Clocking and outputs:
  - Single clock; reset is synchronous, active-high.
  - Outputs are combinational from state plus inputs.
- Reset (i_arst=1):
  - All stall/flush outputs 0, forwards 00, o_mdu_busy 0.
  - Next state RUN; counter 0.
  - Reset mid-MDU aborts the wait.
- Forwarding (always active, including during stalls), per operand:
  - 10 if rs==i_rd_addr_mem and i_reg_we_mem and rs!=0.
  - Else 01 if rs==i_rd_addr_wb and i_reg_we_wb and rs!=0.
  - Else 00.
  - Mem has priority over wb.
- Memory stall (i_icache_stall|i_dcache_stall):
  - Highest priority, any state: all four stalls 1, all flushes 0.
  - FSM state and counter frozen.
  - o_mdu_busy still reflects the state.
- FSM states: RUN, MDU_WAIT, MDU_DONE. Priority in RUN (no memory stall):
  - i_branch_taken_exec: o_flush_decode=1, o_flush_exec=1, no stalls. Overrides load-use.
  - i_mdu_instr_exec: stall fetch/decode/exec, o_flush_mem=1; counter←MDU_LATENCY-2; →MDU_WAIT.
  - Load-use: i_load_instr_exec and i_rd_addr_exec!=0 and it matches i_rs1_addr_dec or i_rs2_addr_dec.
    - Response: stall fetch/decode, o_flush_exec=1, for exactly one cycle.
  - Otherwise all 0.
- MDU_WAIT:
  - Stall fetch/decode/exec, o_flush_mem=1.
  - Load-use and branch are ignored.
  - Counter==1 →MDU_DONE, else decrement.
- MDU_DONE:
  - No stalls; the MDU instruction advances.
  - Branch and load-use are evaluated as in RUN; an MDU in exec is not re-triggered.
  - Unconditionally →RUN.
- MDU exec occupancy is exactly MDU_LATENCY cycles, plus any memory-stall cycles.
- Counter width is $clog2(MDU_LATENCY).

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds 32-bit outputs:
  - o_stall_cycles: increments in every non-reset cycle with o_stall_fetch=1.
  - o_flush_events: increments in every cycle with o_flush_decode|o_flush_exec.
  - Both counters wrap, and reset to 0.
- When undefined, these ports and registers are absent.

Decomposition:
- Package hazard_pkg:
  - State enum t_hazard_state {RUN, MDU_WAIT, MDU_DONE}.
  - Forward encodings FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module forward_sel: combinational rs vs mem/wb compare, instantiated twice (rs1, rs2).

Test Plan:
- Forwarding: rs1_exec=5, rd_mem=5 we, rd_wb=5 we → o_forward_rs1=10.
  - Then rd_mem=0 → 01.
  - Then rs1_exec=0 → 00.
- Load-use: load in exec, rd_exec=7, rs2_dec=7 → one cycle of stall_fetch=stall_decode=1, flush_exec=1; next cycle all 0.
  - Same with rd_exec=0 → no stall.
- Branch and load-use in the same cycle → flush_decode=flush_exec=1, stalls 0.
- MDU, MDU_LATENCY=4, mdu instr in exec:
  - Stall_exec=1 for 3 cycles, then 0 with state MDU_DONE, then RUN.
  - o_mdu_busy=1 for 2 cycles.
- i_dcache_stall=1 for 2 cycles during MDU_WAIT → all stalls 1; MDU stall total extends to 5 cycles.
- Reset asserted in MDU_WAIT → outputs 0 that cycle; RUN next cycle.
  - With HAZARD_PERF_CNT_EN: both counters read 0.
